data_mem_dma: RTL and testbench
===============================

Name: data_mem_dma

Overview:
- Block-transfer controller and port arbiter for the single-port 256x8 data memory.
- Shares the memory between the CPU load/store path (priority requester) and an internal copy/fill engine.
- Firmware or bench uses it to relocate tables (e.g. tap patterns at 130..138) and to clear or fill regions.
- Sits between the CPU datapath and the data memory; the memory's read is combinational and its write is clocked.

Parameters:
STARVE_LIMIT, 8, consecutive DMA-blocked cycles after which the DMA is granted one cycle and the CPU is stalled.

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
Start  input  1  launch transfer; sampled only when Busy=0
Mode  input  1  0=copy, 1=fill
SrcAddr  input  8  copy source base; captured at Start
DstAddr  input  8  destination base; captured at Start
Len  input  8  byte count (0..255); captured at Start
FillByte  input  8  fill value; captured at Start
Busy  output  1  transfer in progress
Done  output  1  one-cycle completion pulse
CpuReq  input  1  CPU wants a memory access this cycle
CpuWriteEn  input  1  CPU write strobe
CpuAddr  input  8  CPU address
CpuDataIn  input  8  CPU write data
CpuDataOut  output  8  read data to CPU (MemDataOut passthrough)
CpuStall  output  1  CPU access not serviced this cycle; CPU holds its request
MemWriteEn  output  1  to memory WriteEn
MemAddr  output  8  to memory DataAddress
MemDataIn  output  8  to memory DataIn
MemDataOut  input  8  from memory DataOut

Behaviour:
- Clk is the only clock. Reset is synchronous and active-high.
- Reset: state=IDLE; Busy=0, Done=0, CpuStall=0; starve counter=0; internal src/dst/len/buffer registers=0.
- Reset mid-transfer aborts immediately. No Done pulse is generated, and bytes already written remain written.
- FSM states: IDLE, READ, WRITE, FINISH.
- IDLE:
  - Start=1 latches SrcAddr, DstAddr, Len, FillByte and Mode.
  - Len=0 goes to FINISH.
  - Otherwise copy goes to READ and fill goes to WRITE.
- READ (copy only): when granted, MemAddr=src and the buffer captures MemDataOut at the edge; then src+=1 and the state goes to WRITE.
- WRITE:
  - When granted, MemAddr=dst, MemWriteEn=1, MemDataIn = buffer (copy) or FillByte (fill).
  - dst+=1 and remaining-=1.
  - If remaining becomes 0, go to FINISH; otherwise go to READ (copy) or stay in WRITE (fill).
- FINISH: Done=1 for exactly this cycle, Busy=0, then return to IDLE.
- Busy=1 in READ and WRITE only.
- Start asserted while Busy=1 is ignored.
- Address arithmetic is 8-bit modulo 256: 255+1 wraps to 0.
- Copies are forward-only. Overlapping regions with dst>src are not memmove-safe; this is documented, not detected.
- Arbitration, evaluated each cycle:
  - DMA pending = state is READ or WRITE.
  - If CpuReq=1 and the starve counter < STARVE_LIMIT, the CPU is granted: Mem* driven from Cpu*, CpuStall=0, the DMA holds its state. If the DMA is also pending, the counter increments.
  - If CpuReq=1 and the counter == STARVE_LIMIT, the DMA is granted, CpuStall=1 (combinational), and the counter clears.
  - If CpuReq=0, the DMA is granted when pending and the counter clears.
  - With no grantee: MemWriteEn=0, MemAddr=0, MemDataIn=0.
- CpuDataOut = MemDataOut in all cycles. It is valid for the CPU only when CpuReq=1 and CpuStall=0.
- Latency with no contention: Start at edge k puts Busy=1 from k+1.
  - Copy: Done is high in cycle k+1+2·Len.
  - Fill: Done is high in cycle k+1+Len.
  - Len=0: Done is high in cycle k+1 and Busy stays 0.
- Each cycle the CPU takes while the DMA is pending delays Done by exactly one cycle.

Decomposition:
- Package data_mem_dma_pkg contains:
  - state enum (IDLE, READ, WRITE, FINISH), 2-bit
  - MODE_COPY=1'b0, MODE_FILL=1'b1
  - ADDR_W=8, DATA_W=8
- No sub-module is warranted; FSM, counters and mux fit in one module (~200 lines).

Test Plan:
- Copy Src=130 Dst=200 Len=3 after memory reset, no CPU traffic -> Core[200..202]=0x60,0x48,0x78; Busy 6 cycles; single Done pulse at k+7.
- Fill Mode=1 Dst=64 Len=4 FillByte=0x20 -> Core[64..67]=0x20; Done at k+5; Core[68] still 0.
- Wrap: fill Dst=254 Len=4 FillByte=0xAA -> Core[254], Core[255], Core[0], Core[1]=0xAA; Core[2] untouched.
- Contention: copy Len=2 with CpuReq=1 on 3 cycles mid-transfer (CPU reads 140 -> CpuDataOut=0x20) -> Done delayed exactly 3 cycles; CpuStall never 1.
- Starvation: CpuReq held 1 for 30 cycles during fill Len=2 with STARVE_LIMIT=8 -> CpuStall=1 on cycles 9 and 18; fill completes; Done pulses; counter clears on each stall.
- Len=0 -> Done in k+1, Busy never 1, no MemWriteEn. Start while Busy is ignored. Reset during WRITE -> Busy=0 next cycle, no Done, later bytes unwritten.

Source files
------------

// File: rtl/data_mem_dma_pkg.sv
// rtl/data_mem_dma_pkg.sv - shared types and constants for the data memory DMA/arbiter
package data_mem_dma_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/data_mem_dma_if.sv
// rtl/data_mem_dma_if.sv - CPU load/store and data memory bus bundle
interface data_mem_dma_if;
  import data_mem_dma_pkg::*;

  // CPU side
  logic              CpuReq;
  logic              CpuWriteEn;
  logic [ADDR_W-1:0] CpuAddr;
  logic [DATA_W-1:0] CpuDataIn;
  logic [DATA_W-1:0] CpuDataOut;
  logic              CpuStall;

  // memory side
  logic              MemWriteEn;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemDataIn;
  logic [DATA_W-1:0] MemDataOut;

  // controller view
  modport master (
    input  CpuReq, CpuWriteEn, CpuAddr, CpuDataIn, MemDataOut,
    output CpuDataOut, CpuStall, MemWriteEn, MemAddr, MemDataIn
  );

  // CPU + memory view
  modport slave (
    output CpuReq, CpuWriteEn, CpuAddr, CpuDataIn, MemDataOut,
    input  CpuDataOut, CpuStall, MemWriteEn, MemAddr, MemDataIn
  );

endinterface

// File: rtl/data_mem_dma.sv
// rtl/data_mem_dma.sv - copy/fill engine and CPU-priority arbiter for the 256x8 data memory
module data_mem_dma
  import data_mem_dma_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mode,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [7:0]        Len,
  input  logic [DATA_W-1:0] FillByte,
  output logic              Busy,
  output logic              Done,
  data_mem_dma_if.master    bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [7:0]        rem_q, rem_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic              pending;
  logic              cpu_gnt;
  logic              dma_gnt;
  logic              stall;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;

  assign pending = (state_q == READ) || (state_q == WRITE);

  // Arbitration: CPU wins unless the engine has been blocked STARVE_LIMIT cycles in a row
  always_comb begin
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    stall    = 1'b0;
    starve_d = starve_q;
    if (bus.CpuReq) begin
      if (pending && (starve_q >= LIMIT_C)) begin
        dma_gnt  = 1'b1;
        stall    = 1'b1;
        starve_d = '0;
      end else begin
        cpu_gnt = 1'b1;
        if (pending) begin
          starve_d = starve_q + CNT_W'(1);
        end
      end
    end else begin
      dma_gnt  = pending;
      starve_d = '0;
    end
  end

  // Transfer FSM: next state, address/count updates and engine-side memory request
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    buf_d     = buf_q;
    fill_d    = fill_q;
    mode_d    = mode_q;
    dma_we    = 1'b0;
    dma_addr  = '0;
    dma_wdata = '0;
    Busy      = 1'b0;
    Done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          src_d  = SrcAddr;
          dst_d  = DstAddr;
          rem_d  = Len;
          fill_d = FillByte;
          mode_d = Mode;
          if (Len == 8'd0) begin
            state_d = FINISH;
          end else if (Mode == MODE_FILL) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        Busy     = 1'b1;
        dma_addr = src_q;
        if (dma_gnt) begin
          buf_d   = bus.MemDataOut;
          src_d   = src_q + 8'd1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        Busy      = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = dst_q;
        dma_wdata = (mode_q == MODE_FILL) ? fill_q : buf_q;
        if (dma_gnt) begin
          dst_d = dst_q + 8'd1;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = FINISH;
          end else if (mode_q == MODE_COPY) begin
            state_d = READ;
          end
        end
      end
      FINISH: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port mux; read data always passes straight through to the CPU
  always_comb begin
    bus.CpuDataOut = bus.MemDataOut;
    bus.CpuStall   = stall;
    bus.MemWriteEn = 1'b0;
    bus.MemAddr    = '0;
    bus.MemDataIn  = '0;
    if (cpu_gnt) begin
      bus.MemWriteEn = bus.CpuWriteEn;
      bus.MemAddr    = bus.CpuAddr;
      bus.MemDataIn  = bus.CpuDataIn;
    end else if (dma_gnt) begin
      bus.MemWriteEn = dma_we;
      bus.MemAddr    = dma_addr;
      bus.MemDataIn  = dma_wdata;
    end
  end

  // State and datapath registers; reset aborts any transfer in flight
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      buf_q    <= '0;
      fill_q   <= '0;
      mode_q   <= MODE_COPY;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      buf_q    <= buf_d;
      fill_q   <= fill_d;
      mode_q   <= mode_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_data_mem_dma.sv
// tb/tb_data_mem_dma.sv - scoreboard bench for data_mem_dma
module tb_data_mem_dma;
  import data_mem_dma_pkg::*;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Mode = 1'b0;
  logic [7:0] SrcAddr = '0;
  logic [7:0] DstAddr = '0;
  logic [7:0] Len = '0;
  logic [7:0] FillByte = '0;
  logic       Busy;
  logic       Done;

  logic [7:0] core [256];
  int         cyc = 0;
  int         busy_cnt = 0;
  int         n_vec = 0;
  int         n_err = 0;

  wr_t        wr_q [$];
  int         done_q [$];
  int         stall_q [$];

  data_mem_dma_if bus ();

  data_mem_dma #(.STARVE_LIMIT(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Mode     (Mode),
    .SrcAddr  (SrcAddr),
    .DstAddr  (DstAddr),
    .Len      (Len),
    .FillByte (FillByte),
    .Busy     (Busy),
    .Done     (Done),
    .bus      (bus)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  assign bus.MemDataOut = core[bus.MemAddr];
  always @(posedge Clk) begin
    if (bus.MemWriteEn) core[bus.MemAddr] <= bus.MemDataIn;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output side of the scoreboard: every write, Done pulse and stall is popped and compared
  always @(negedge Clk) begin
    if (Busy) busy_cnt++;
    if (bus.MemWriteEn) begin
      if (wr_q.size() == 0) begin
        check_eq("wr_expected", wr_q.size(), 1);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check_eq("wr_addr", bus.MemAddr, e.a);
        check_eq("wr_data", bus.MemDataIn, e.d);
      end
    end
    if (Done) begin
      if (done_q.size() == 0) check_eq("done_expected", done_q.size(), 1);
      else check_eq("done_cycle", cyc, done_q.pop_front());
    end
    if (bus.CpuStall) begin
      if (stall_q.size() == 0) check_eq("stall_expected", stall_q.size(), 1);
      else check_eq("stall_cycle", cyc, stall_q.pop_front());
    end
  end

  task automatic launch(input logic m, input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] l, input logic [7:0] f, output int k);
    @(negedge Clk);
    Mode = m; SrcAddr = s; DstAddr = d; Len = l; FillByte = f; Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    k = cyc;
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    wr_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      #1;
      if (wr_q.size() == 0 && done_q.size() == 0 && stall_q.size() == 0) break;
    end
    check_eq(tag, wr_q.size() + done_q.size() + stall_q.size(), 0);
    repeat (3) @(posedge Clk);
    #1;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) core[i] = 8'h00;
    core[130] = 8'h60; core[131] = 8'h48; core[132] = 8'h78;
    core[133] = 8'h72; core[134] = 8'hB4; core[135] = 8'hFA;
    core[136] = 8'hF3; core[137] = 8'hD7; core[138] = 8'hE1;
    core[140] = 8'h20;
    bus.CpuReq = 1'b0; bus.CpuWriteEn = 1'b0; bus.CpuAddr = '0; bus.CpuDataIn = '0;

    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_done", Done, 0);
    check_eq("rst_stall", bus.CpuStall, 0);
    check_eq("rst_mwe", bus.MemWriteEn, 0);
    check_eq("rst_maddr", bus.MemAddr, 0);

    // copy 130..132 -> 200..202
    busy_cnt = 0;
    launch(MODE_COPY, 8'd130, 8'd200, 8'd3, 8'h00, k);
    push_wr(8'd200, 8'h60); push_wr(8'd201, 8'h48); push_wr(8'd202, 8'h78);
    done_q.push_back(k + 6);
    drain("copy_drain");
    check_eq("copy_busy_cycles", busy_cnt, 6);
    check_eq("copy_core202", core[202], 8'h78);

    // fill 64..67 with 0x20
    busy_cnt = 0;
    launch(MODE_FILL, 8'd0, 8'd64, 8'd4, 8'h20, k);
    for (int i = 0; i < 4; i++) push_wr(8'(64 + i), 8'h20);
    done_q.push_back(k + 4);
    drain("fill_drain");
    check_eq("fill_busy_cycles", busy_cnt, 4);
    check_eq("fill_core68", core[68], 8'h00);

    // fill across the 255 -> 0 wrap
    launch(MODE_FILL, 8'd0, 8'd254, 8'd4, 8'hAA, k);
    push_wr(8'd254, 8'hAA); push_wr(8'd255, 8'hAA); push_wr(8'd0, 8'hAA); push_wr(8'd1, 8'hAA);
    done_q.push_back(k + 4);
    drain("wrap_drain");
    check_eq("wrap_core0", core[0], 8'hAA);
    check_eq("wrap_core2", core[2], 8'h00);

    // CPU reads 140 for three cycles in the middle of a two-byte copy
    launch(MODE_COPY, 8'd130, 8'd210, 8'd2, 8'h00, k);
    push_wr(8'd210, 8'h60); push_wr(8'd211, 8'h48);
    done_q.push_back(k + 4 + 3);
    @(posedge Clk);
    #1;
    bus.CpuReq = 1'b1; bus.CpuAddr = 8'd140;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check_eq("cont_cpu_data", bus.CpuDataOut, 8'h20);
      check_eq("cont_cpu_stall", bus.CpuStall, 0);
      @(posedge Clk);
      #1;
    end
    bus.CpuReq = 1'b0;
    drain("cont_drain");

    // CPU hogs the port: engine forced through every ninth pending cycle
    bus.CpuReq = 1'b1; bus.CpuAddr = 8'd140;
    launch(MODE_FILL, 8'd0, 8'd100, 8'd2, 8'h55, k);
    push_wr(8'd100, 8'h55); push_wr(8'd101, 8'h55);
    stall_q.push_back(k + 8); stall_q.push_back(k + 17);
    done_q.push_back(k + 18);
    repeat (29) @(posedge Clk);
    #1;
    bus.CpuReq = 1'b0;
    drain("starve_drain");
    check_eq("starve_core101", core[101], 8'h55);

    // zero-length transfer
    busy_cnt = 0;
    launch(MODE_COPY, 8'd130, 8'd150, 8'd0, 8'h00, k);
    done_q.push_back(k);
    drain("len0_drain");
    check_eq("len0_busy_cycles", busy_cnt, 0);

    // Start while busy must be ignored
    launch(MODE_FILL, 8'd0, 8'd20, 8'd3, 8'h33, k);
    for (int i = 0; i < 3; i++) push_wr(8'(20 + i), 8'h33);
    done_q.push_back(k + 3);
    Mode = MODE_FILL; DstAddr = 8'd30; Len = 8'd5; FillByte = 8'h44; Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    drain("busy_start_drain");
    check_eq("busy_start_core30", core[30], 8'h00);

    // reset while writing: two bytes land, the rest never do, no Done
    launch(MODE_FILL, 8'd0, 8'd40, 8'd4, 8'h77, k);
    push_wr(8'd40, 8'h77); push_wr(8'd41, 8'h77);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    check_eq("rst_mid_busy", Busy, 0);
    drain("rst_mid_drain");
    check_eq("rst_mid_core41", core[41], 8'h77);
    check_eq("rst_mid_core42", core[42], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
